// File: rtl/photonic_dot_accumulator_pkg.sv
// Shared constants, state encoding and helpers for the photonic dot-product accumulator.
// The optional PHOTONIC_ACC_SATURATE_EN macro is consumed by the top module, not here.
package photonic_pkg;

  localparam int SAMPLES_PER_BEAT = 16;
  localparam int SAMPLE_WIDTH     = 16;
  localparam int VALUE_LSB        = 7;
  localparam int VALUE_WIDTH      = 8;
  localparam int TREE_LATENCY     = 2;

  localparam int BEAT_WIDTH   = SAMPLES_PER_BEAT * SAMPLE_WIDTH;
  localparam int TREE_GROUPS  = 4;
  localparam int STAGE1_WIDTH = 10;
  localparam int SUM_WIDTH    = 12;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic logic [STAGE1_WIDTH-1:0] ext_value(input logic [VALUE_WIDTH-1:0] v);
    return {{(STAGE1_WIDTH - VALUE_WIDTH){1'b0}}, v};
  endfunction

endpackage

// File: rtl/photonic_dot_accumulator_if.sv
// Stream, control and status bundle between the multiplier/driver side (master)
// and the dot-product accumulator (slave).
interface photonic_dot_accumulator_if #(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) ();
  import photonic_pkg::*;

  logic [BEAT_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic [ACC_WIDTH-1:0]  m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  busy;
  logic                  drop;
  logic                  ovf;

  modport master (
    output s_axis_tdata, s_axis_tvalid, start, len, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, busy, drop, ovf
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, start, len, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, busy, drop, ovf
  );

endinterface

// File: rtl/photonic_dot_accumulator_beat_adder_tree.sv
// Two-stage reduction of one 16-sample beat: 16 -> 4 partial sums, then 4 -> 1.
// Only the 8-bit value field of each sample takes part; all other bits are ignored.
module beat_adder_tree
  import photonic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BEAT_WIDTH-1:0] beat_i,
  input  logic                  valid_i,
  output logic [SUM_WIDTH-1:0]  sum_o,
  output logic                  valid_o
);

  logic [VALUE_WIDTH-1:0]  value_w     [SAMPLES_PER_BEAT];
  logic [STAGE1_WIDTH-1:0] group_sum_d [TREE_GROUPS];
  logic [STAGE1_WIDTH-1:0] group_sum_q [TREE_GROUPS];
  logic                    stage1_vld_q;
  logic [SUM_WIDTH-1:0]    sum_d;
  logic [SUM_WIDTH-1:0]    sum_q;
  logic                    sum_vld_q;

  for (genvar gi = 0; gi < SAMPLES_PER_BEAT; gi++) begin : g_extract
    assign value_w[gi] = beat_i[gi*SAMPLE_WIDTH + VALUE_LSB +: VALUE_WIDTH];
  end

  // Four samples of at most 255 fit in 10 bits (max 1020).
  for (genvar gi = 0; gi < TREE_GROUPS; gi++) begin : g_group
    assign group_sum_d[gi] = ext_value(value_w[gi*4])     + ext_value(value_w[gi*4 + 1])
                           + ext_value(value_w[gi*4 + 2]) + ext_value(value_w[gi*4 + 3]);
  end

  assign sum_d = {2'b00, group_sum_q[0]} + {2'b00, group_sum_q[1]}
               + {2'b00, group_sum_q[2]} + {2'b00, group_sum_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TREE_GROUPS; i++) group_sum_q[i] <= '0;
      stage1_vld_q <= 1'b0;
      sum_q        <= '0;
      sum_vld_q    <= 1'b0;
    end else begin
      for (int i = 0; i < TREE_GROUPS; i++) group_sum_q[i] <= group_sum_d[i];
      stage1_vld_q <= valid_i;
      sum_q        <= sum_d;
      sum_vld_q    <= stage1_vld_q;
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = sum_vld_q;

endmodule

// File: rtl/photonic_dot_accumulator.sv
// Accumulates a programmed number of reduced beats into one dot-product result.
// Define PHOTONIC_ACC_SATURATE_EN to saturate the accumulator instead of wrapping.
module photonic_dot_accumulator
  import photonic_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  photonic_dot_accumulator_if.slave  bus
);

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES);

  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_d;
  logic [1:0]             drain_cnt_q;
  logic                   busy_q;
  logic                   tvalid_q;
  logic                   drop_q;
  logic [ACC_WIDTH-1:0]   data_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_d;
  logic [ACC_WIDTH:0]     acc_sum;
  logic                   ovf_q;

  logic                   handshake;
  logic                   start_ok;
  logic                   start_rej;
  logic                   beat_take;
  logic                   beat_last;
  logic [LEN_WIDTH-1:0]   len_lim;

  logic [SUM_WIDTH-1:0]   tree_sum;
  logic                   tree_vld;

  always_comb begin
    handshake  = (state_q == HOLD) && bus.m_axis_tready;
    start_ok   = bus.start && (bus.len != '0) && ((state_q == IDLE) || handshake);
    start_rej  = bus.start && (state_q != IDLE) && !handshake;
    beat_take  = bus.s_axis_tvalid && (start_ok || (state_q == ACCUM));
    len_lim    = start_ok ? bus.len : len_q;
    beat_cnt_d = (start_ok ? '0 : beat_cnt_q) + LEN_WIDTH'(beat_take);
    beat_last  = beat_take && (beat_cnt_d == len_lim);
  end

  beat_adder_tree u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .beat_i  (bus.s_axis_tdata),
    .valid_i (beat_take),
    .sum_o   (tree_sum),
    .valid_o (tree_vld)
  );

  // DRAIN is entered on the last-beat edge; the extra count keeps the result
  // edge four cycles after that beat, well past the accumulator's final update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      drop_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      drop_q <= start_rej;
      if (start_ok) begin
        state_q     <= beat_last ? DRAIN : ACCUM;
        len_q       <= bus.len;
        beat_cnt_q  <= beat_cnt_d;
        drain_cnt_q <= '0;
        busy_q      <= 1'b1;
        tvalid_q    <= 1'b0;
      end else begin
        case (state_q)
          ACCUM: begin
            if (beat_take) begin
              beat_cnt_q <= beat_cnt_d;
              if (beat_last) begin
                state_q     <= DRAIN;
                drain_cnt_q <= '0;
              end
            end
          end
          DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
              state_q  <= HOLD;
              tvalid_q <= 1'b1;
              data_q   <= acc_q;
            end else begin
              drain_cnt_q <= drain_cnt_q + 2'd1;
            end
          end
          HOLD: begin
            if (handshake) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              tvalid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    acc_sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - SUM_WIDTH){1'b0}}, tree_sum};
`ifdef PHOTONIC_ACC_SATURATE_EN
    acc_d = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
    acc_d = acc_sum[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_ok) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (tree_vld) begin
      acc_q <= acc_d;
      if (acc_sum[ACC_WIDTH]) ovf_q <= 1'b1;
    end
  end

  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.busy          = busy_q;
  assign bus.drop          = drop_q;
  assign bus.ovf           = ovf_q;

endmodule
